// File: rtl/interrupt_ack_sequencer.sv
// INTA handshake and EOI sequencer for an 8259-style PIC: drives INT, the vector byte and the ISR/rotation state.
// Optional auto-EOI support is enabled by defining PIC_AUTO_EOI_EN (adds the aeoi_mode input).
module interrupt_ack_sequencer #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
`ifdef PIC_AUTO_EOI_EN
  input  logic       aeoi_mode,
`endif
  output logic       int_out,
  output logic [7:0] clear_request,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       inta_q;
  logic       int_out_q, int_out_d;
  logic [7:0] clear_request_q, clear_request_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rotate_q, rotate_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_out_en_q, data_out_en_d;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;

  logic       inta_fall, inta_rise;
  logic [2:0] req_level;
  logic [2:0] rot_shift;
  logic [15:0] isr_dbl_r;
  logic [7:0] isr_rot;
  logic [7:0] isr_low;
  logic [15:0] low_dbl_l;
  logic [7:0] hlis;
  logic [2:0] hlis_level;
  logic [7:0] eoi_mask;
  logic [2:0] eoi_target;
  logic       eoi_hit;
  logic [7:0] set_mask;
  logic [7:0] aeoi_mask;

  // prev = registered inta_n, now = live inta_n
  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  always_comb begin
    req_level = SPURIOUS_LEVEL;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt[i]) req_level = 3'(i);
    end
  end

  // Rotate so the highest-priority level lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_shift = rotate_q + 3'd1;
    isr_dbl_r = {isr_q, isr_q} >> rot_shift;
    isr_rot   = isr_dbl_r[7:0];
    isr_low   = isr_rot & (~isr_rot + 8'd1);
    low_dbl_l = {isr_low, isr_low} << rot_shift;
    hlis      = low_dbl_l[15:8];
  end

  always_comb begin
    hlis_level = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (hlis[i]) hlis_level = 3'(i);
    end
  end

  always_comb begin
    eoi_mask   = 8'h00;
    eoi_target = 3'd0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_mask   = 8'b1 << eoi_level;
        eoi_target = eoi_level;
      end else begin
        eoi_mask   = hlis;
        eoi_target = hlis_level;
      end
    end
    eoi_hit = |(eoi_mask & isr_q);
  end

  always_comb begin
    state_d         = state_q;
    int_out_d       = 1'b0;
    clear_request_d = 8'h00;
    set_mask        = 8'h00;
    aeoi_mask       = 8'h00;
    data_out_d      = data_out_q;
    data_out_en_d   = data_out_en_q;
    ack_level_d     = ack_level_q;
    spurious_d      = spurious_q;
    case (state_q)
      IDLE: begin
        int_out_d = |interrupt;
        if (inta_fall) begin
          ack_level_d = req_level;
          spurious_d  = ~|interrupt;
          if (|interrupt) begin
            set_mask        = 8'b1 << req_level;
            clear_request_d = 8'b1 << req_level;
          end
          int_out_d = 1'b0;
          state_d   = ACK1;
        end
      end
      ACK1: begin
        if (inta_rise) state_d = GAP;
      end
      GAP: begin
        if (inta_fall) begin
          data_out_d    = {vector_base, ack_level_q};
          data_out_en_d = 1'b1;
          state_d       = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          data_out_d    = 8'h00;
          data_out_en_d = 1'b0;
          state_d       = IDLE;
`ifdef PIC_AUTO_EOI_EN
          if (aeoi_mode && !spurious_q) aeoi_mask = 8'b1 << ack_level_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // An ISR set on the first INTA fall overrides an EOI clear of the same bit.
    isr_d    = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
    rotate_d = (eoi_rotate && eoi_hit) ? eoi_target : rotate_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      inta_q          <= 1'b1;
      int_out_q       <= 1'b0;
      clear_request_q <= 8'h00;
      isr_q           <= 8'h00;
      rotate_q        <= 3'b111;
      data_out_q      <= 8'h00;
      data_out_en_q   <= 1'b0;
      ack_level_q     <= 3'd0;
      spurious_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      inta_q          <= inta_n;
      int_out_q       <= int_out_d;
      clear_request_q <= clear_request_d;
      isr_q           <= isr_d;
      rotate_q        <= rotate_d;
      data_out_q      <= data_out_d;
      data_out_en_q   <= data_out_en_d;
      ack_level_q     <= ack_level_d;
      spurious_q      <= spurious_d;
    end
  end

  assign int_out                  = int_out_q;
  assign clear_request            = clear_request_q;
  assign in_service_register      = isr_q;
  assign highest_level_in_service = hlis;
  assign priority_rotate          = rotate_q;
  assign data_out                 = data_out_q;
  assign data_out_en              = data_out_en_q;
  assign state_dbg                = state_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: directed test-plan cases plus randomized handshakes/EOIs
// checked against a priority-list model of the ISR and rotation.
module tb_interrupt_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] interrupt = 8'h00;
  logic       inta_n = 1'b1;
  logic [4:0] vector_base = 5'b01000;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic       eoi_rotate = 1'b0;
  logic [2:0] eoi_level = 3'd0;
`ifdef PIC_AUTO_EOI_EN
  logic       aeoi_mode = 1'b0;
`endif
  logic       int_out;
  logic [7:0] clear_request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // Reference model: ISR as a bit array, rotation as an integer lowest-priority level.
  bit [7:0] m_isr = 8'h00;
  int       m_rot = 7;
  bit       m_aeoi = 1'b0;

  interrupt_ack_sequencer dut (
    .clock(clock),
    .reset(reset),
    .interrupt(interrupt),
    .inta_n(inta_n),
    .vector_base(vector_base),
    .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific),
    .eoi_rotate(eoi_rotate),
    .eoi_level(eoi_level),
`ifdef PIC_AUTO_EOI_EN
    .aeoi_mode(aeoi_mode),
`endif
    .int_out(int_out),
    .clear_request(clear_request),
    .in_service_register(in_service_register),
    .highest_level_in_service(highest_level_in_service),
    .priority_rotate(priority_rotate),
    .data_out(data_out),
    .data_out_en(data_out_en),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walk levels from highest priority (just after m_rot) to lowest.
  function automatic int m_hlis_lvl();
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (m_rot + k) % 8;
      if (m_isr[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_hlis();
    int l;
    l = m_hlis_lvl();
    return (l < 0) ? 8'h00 : (8'h01 << l);
  endfunction

  function automatic void m_eoi(input bit spec, input bit rot, input int lvl);
    int  target;
    bit  hit;
    if (spec) begin
      target = lvl;
      hit    = m_isr[target];
    end else begin
      target = m_hlis_lvl();
      hit    = (target >= 0);
    end
    if (hit) begin
      m_isr[target] = 1'b0;
      if (rot) m_rot = target;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_isr"}, in_service_register, m_isr);
    check({tag, "_rot"}, priority_rotate, m_rot);
    check({tag, "_hlis"}, highest_level_in_service, m_hlis());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    interrupt = 8'h00;
    inta_n = 1'b1;
    eoi_valid = 1'b0;
    #3;
    check("rst_int_out", int_out, 0);
    check("rst_clr", clear_request, 0);
    check("rst_en", data_out_en, 0);
    check("rst_dout", data_out, 0);
    check("rst_state", state_dbg, 0);
    tick();
    reset = 1'b0;
    m_isr = 8'h00;
    m_rot = 7;
    check_model("rst");
  endtask

  task automatic do_eoi(input bit spec, input bit rot, input logic [2:0] lvl);
    eoi_valid = 1'b1;
    eoi_specific = spec;
    eoi_rotate = rot;
    eoi_level = lvl;
    tick();
    eoi_valid = 1'b0;
    m_eoi(spec, rot, lvl);
    check_model("eoi");
  endtask

  // Full two-pulse INTA sequence; optionally issues a rotate-free specific EOI on the first fall.
  task automatic handshake(input logic [7:0] irq, input logic [7:0] irq_late,
                           input bit eoi_at_fall, input logic [2:0] eoi_lvl_f);
    int lvl;
    logic [7:0] vec;
    interrupt = irq;
    tick();
    check("int_out_raise", int_out, irq != 0);
    lvl = 7;
    for (int i = 7; i >= 0; i--) if (irq[i]) lvl = i;
    inta_n = 1'b0;
    if (eoi_at_fall) begin
      eoi_valid = 1'b1;
      eoi_specific = 1'b1;
      eoi_rotate = 1'b0;
      eoi_level = eoi_lvl_f;
    end
    tick();
    eoi_valid = 1'b0;
    if (eoi_at_fall) m_eoi(1'b1, 1'b0, eoi_lvl_f);
    if (irq != 0) m_isr[lvl] = 1'b1;
    exp_q.push_back({vector_base, 3'(lvl)});
    check("clr_pulse", clear_request, (irq != 0) ? (8'h01 << lvl) : 8'h00);
    check("int_out_ack", int_out, 0);
    check_model("ack1");
    interrupt = irq_late;
    tick();
    check("clr_one_cycle", clear_request, 0);
    check("state_ack1", state_dbg, 1);
    inta_n = 1'b1;
    tick();
    check("gap_int_out", int_out, 0);
    check("gap_en", data_out_en, 0);
    tick();
    inta_n = 1'b0;
    tick();
    vec = exp_q.pop_front();
    check("ack2_en", data_out_en, 1);
    check("ack2_vec", data_out, vec);
    tick();
    check("ack2_hold", data_out, vec);
    inta_n = 1'b1;
    tick();
    if (m_aeoi && irq != 0) m_isr[lvl] = 1'b0;
    check("end_en", data_out_en, 0);
    check("end_dout", data_out, 0);
    check("end_state", state_dbg, 0);
    check("end_int_out", int_out, 0);
    check_model("end");
    tick();
    check("int_out_reassert", int_out, |irq_late);
    interrupt = 8'h00;
  endtask

  initial begin
    // Single ack with vector 0x42
    do_reset();
    vector_base = 5'b01000;
    handshake(8'h04, 8'h00, 1'b0, 3'd0);
    check("tp1_isr", in_service_register, 8'h04);

    // Spurious ack drives level 7, ISR untouched
    do_reset();
    handshake(8'h00, 8'h00, 1'b0, 3'd0);
    check("tp2_isr", in_service_register, 8'h00);

    // Non-specific EOI sequence
    do_reset();
    handshake(8'h02, 8'h00, 1'b0, 3'd0);
    handshake(8'h08, 8'h00, 1'b0, 3'd0);
    check("tp3_isr0", in_service_register, 8'h0A);
    do_eoi(1'b0, 1'b0, 3'd0);
    check("tp3_isr1", in_service_register, 8'h08);
    do_eoi(1'b0, 1'b0, 3'd0);
    check("tp3_isr2", in_service_register, 8'h00);
    do_eoi(1'b0, 1'b1, 3'd0);
    check("tp3_noop_rot", priority_rotate, 3'd7);

    // Specific EOI with rotate
    do_reset();
    handshake(8'h10, 8'h00, 1'b0, 3'd0);
    handshake(8'h20, 8'h00, 1'b0, 3'd0);
    do_eoi(1'b1, 1'b1, 3'd4);
    check("tp4_isr", in_service_register, 8'h20);
    check("tp4_rot", priority_rotate, 3'd4);
    check("tp4_hlis", highest_level_in_service, 8'h20);

    // Set wins over a same-cycle EOI on the same bit; other bits clear normally
    do_reset();
    handshake(8'h04, 8'h00, 1'b0, 3'd0);
    handshake(8'h04, 8'h00, 1'b1, 3'd2);
    check("setwins_isr", in_service_register, 8'h04);
    handshake(8'h02, 8'h00, 1'b1, 3'd2);
    check("other_clr_isr", in_service_register, 8'h02);

    // Reset in ACK2
    do_reset();
    interrupt = 8'h04;
    tick();
    inta_n = 1'b0;
    tick();
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check("pre_rst_en", data_out_en, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_rst_en", data_out_en, 0);
    check("async_rst_state", state_dbg, 0);
    check("async_rst_isr", in_service_register, 0);
    check("async_rst_rot", priority_rotate, 3'd7);
    do_reset();

`ifdef PIC_AUTO_EOI_EN
    aeoi_mode = 1'b1;
    m_aeoi = 1'b1;
    handshake(8'h80, 8'h00, 1'b0, 3'd0);
    check("aeoi_isr", in_service_register, 8'h00);
    aeoi_mode = 1'b0;
    m_aeoi = 1'b0;
    do_reset();
`endif

    // Randomized mix of handshakes and EOIs
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 2);
      vector_base = 5'($urandom_range(0, 31));
      if (r == 0) begin
        logic [7:0] irq;
        logic [7:0] late;
        irq  = ($urandom_range(0, 8) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
        late = ($urandom_range(0, 1) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
        handshake(irq, late, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end else begin
        do_eoi(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
